// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
// The core drives the master modport; the LSU uses the slave modport.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-only memory, read-modify-write for SB/SH; one request in flight.
// Accept->rsp: load/SW 2, SB/SH 3, error 1 cycles; rsp held until rsp_ready. LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module load_store_unit #(
   parameter int MEM_ADDR_BITS = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave core,
   output logic [31:0]      mem_access_addr,
   output logic [31:0]      mem_in,
   output logic             mem_write_en,
   output logic             mem_read_en,
   input  logic [31:0]      mem_out
);
   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t                   state, state_nxt;
   logic [MEM_ADDR_BITS-1:0] addr_q;
   logic [31:0]              wdata_q;
   logic [31:0]              merged_q;
   logic [31:0]              rdata_q;
   logic [2:0]               funct3_q;
   logic                     err_q;

   logic                     accept;
   logic                     req_illegal;
   logic                     req_misalign;
   logic                     req_err;
   logic [1:0]               offset;
   logic [7:0]               lane_b;
   logic [15:0]              lane_h;
   logic [31:0]              load_ext;
   logic [31:0]              merged;
   logic [31:0]              word_addr;
   logic                     unused_addr_hi;

   assign unused_addr_hi = ^core.req_addr[31:MEM_ADDR_BITS];
   assign accept         = core.req_valid && core.req_ready;
   assign offset         = addr_q[1:0];
   assign word_addr      = {{(32-MEM_ADDR_BITS){1'b0}}, addr_q[MEM_ADDR_BITS-1:2], 2'b00};

   always_comb begin
      if (core.req_store)
         req_illegal = !(core.req_funct3 inside {F3_B, F3_H, F3_W});
      else
         req_illegal = !(core.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (core.req_funct3[1:0])
         2'b01:   req_misalign = core.req_addr[0];
         2'b10:   req_misalign = |core.req_addr[1:0];
         default: req_misalign = 1'b0;
      endcase
   end
`else
   assign req_misalign = 1'b0;
`endif

   assign req_err = req_illegal | req_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                   state_nxt = RESP;
               else if (!core.req_store)      state_nxt = LOAD;
               else if (core.req_funct3 == F3_W) state_nxt = WRITE;
               else                           state_nxt = RMW_RD;
            end
         end
         LOAD:    state_nxt = RESP;
         RMW_RD:  state_nxt = WRITE;
         WRITE:   state_nxt = RESP;
         RESP:    if (core.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Halfword lanes use only offset[1], so misaligned halfwords fall back to aligned when not trapped.
   always_comb begin
      lane_b = mem_out[{offset, 3'b000} +: 8];
      lane_h = mem_out[{offset[1], 4'b0000} +: 16];
      case (funct3_q)
         F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_ext = {24'd0, lane_b};
         F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_ext = {16'd0, lane_h};
         default: load_ext = mem_out;
      endcase
      merged = mem_out;
      if (funct3_q == F3_H) merged[{offset[1], 4'b0000} +: 16] = wdata_q[15:0];
      else                  merged[{offset, 3'b000} +: 8]      = wdata_q[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         merged_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= core.req_addr[MEM_ADDR_BITS-1:0];
            wdata_q  <= core.req_wdata;
            funct3_q <= core.req_funct3;
            rdata_q  <= '0;
            err_q    <= req_err;
         end
         if (state == LOAD)   rdata_q  <= load_ext;
         if (state == RMW_RD) merged_q <= merged;
      end
   end

   always_comb begin
      mem_read_en     = 1'b0;
      mem_write_en    = 1'b0;
      mem_access_addr = '0;
      mem_in          = '0;
      case (state)
         LOAD, RMW_RD: begin
            mem_read_en     = 1'b1;
            mem_access_addr = word_addr;
         end
         WRITE: begin
            mem_write_en    = 1'b1;
            mem_access_addr = word_addr;
            mem_in          = (funct3_q == F3_W) ? wdata_q : merged_q;
         end
         default: ;
      endcase
   end

   assign core.req_ready = (state == IDLE) && rst_n;
   assign core.rsp_valid = (state == RESP);
   assign core.rsp_rdata = rdata_q;
   assign core.rsp_err   = err_q;
endmodule
